sram_rr_scheduler: RTL and testbench

SRAM_RR_SCHEDULER -- requirements
Module: sram_rr_scheduler

---
 rtl/sram_rr_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_sram_rr_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_scheduler.sv
// sram_rr_scheduler: round-robin arbiter giving four requesters access to a single-port
// SRAM with fixed read latency SRAM_LAT. One access is outstanding at a time. A requester
// that is acknowledged is masked for that cycle so the other requesters get their turn.
// Optional build macro SRAM_SCHED_MEM_CLEAR_EN adds a power-up sweep that zeroes every word.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-low reset
//   req/we[3:0]             per-requester level request and direction (1=write)
//   addr/wdata              packed per-requester address and write data
//   ack[3:0]                one-cycle completion pulse; rdata valid with it
//   rdata                   read data of the most recent read completion
//   busy, clear_done        access/sweep in progress, memory usable
//   mem_en/mem_we/mem_addr/mem_wdata   registered SRAM controls
//   mem_rdata               SRAM read data
module sram_rr_scheduler #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SRAM_LAT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [3:0]            we,
    input  logic [4*ADDR_W-1:0]   addr,
    input  logic [4*DATA_W-1:0]   wdata,
    output logic [3:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SRAM_LAT - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

`ifdef SRAM_SCHED_MEM_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_ptr, w_ptr_nxt;
    logic [1:0]          r_gnt, w_gnt_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [3:0]          r_ack, w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_clear_done, w_clear_done_nxt;
    logic                r_mem_en, w_mem_en_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;

    logic [3:0]          w_elig;
    logic [1:0]          w_cand;
    logic [1:0]          w_pick;
    logic                w_found;

    // A requester acknowledged this cycle is not eligible again until next cycle
    assign w_elig = req & ~r_ack;

    // First eligible requester searching upward from r_ptr, wrapping modulo 4
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= RESET_STATE;
            r_ptr        <= 2'd0;
            r_gnt        <= 2'd0;
            r_cnt        <= '0;
            r_ack        <= 4'd0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_gnt        <= w_gnt_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_rdata      <= w_rdata_nxt;
            r_busy       <= w_busy_nxt;
            r_clear_done <= w_clear_done_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_gnt_nxt        = r_gnt;
        w_cnt_nxt        = r_cnt;
        w_ack_nxt        = 4'd0;
        w_rdata_nxt      = r_rdata;
        w_busy_nxt       = r_busy;
        w_clear_done_nxt = r_clear_done;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
`ifndef SRAM_SCHED_MEM_CLEAR_EN
        w_clear_done_nxt = 1'b1;
`endif

        case (r_state)
`ifdef SRAM_SCHED_MEM_CLEAR_EN
            // Sweep: mem_addr doubles as the sweep pointer; mem_en low marks the first write
            ST_CLEAR: begin
                if (r_mem_en && (r_mem_addr == '1)) begin
                    w_busy_nxt       = 1'b0;
                    w_clear_done_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_mem_en ? (r_mem_addr + 1'b1) : '0;
                    w_mem_wdata_nxt = '0;
                    w_busy_nxt      = 1'b1;
                end
            end
`endif
            // Wait out the SRAM latency, then complete; only reads update rdata
            ST_ACCESS: begin
                if (r_cnt == LAST_CNT) begin
                    if (!r_mem_we) begin
                        w_rdata_nxt = mem_rdata;
                    end
                    w_ack_nxt[r_gnt] = 1'b1;
                    w_busy_nxt       = 1'b0;
                    w_ptr_nxt        = r_gnt + 2'd1;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (r_clear_done && w_found) begin
                    w_gnt_nxt       = w_pick;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = we[w_pick];
                    w_mem_addr_nxt  = addr[w_pick*ADDR_W +: ADDR_W];
                    w_mem_wdata_nxt = wdata[w_pick*DATA_W +: DATA_W];
                    w_cnt_nxt       = '0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = ST_ACCESS;
                end
            end
        endcase
    end

    assign ack        = r_ack;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign clear_done = r_clear_done;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// tb_sram_rr_scheduler: directed plus randomized bench for sram_rr_scheduler. A transaction-
// level reference model (grant by round-robin search, completion SRAM_LAT edges later,
// reference memory updated at grant) predicts every output each cycle. Honours the
// SRAM_SCHED_MEM_CLEAR_EN build macro.
module tb_sram_rr_scheduler;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LAT    = 3;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [3:0]            req   = '0;
    logic [3:0]            we    = '0;
    logic [4*ADDR_W-1:0]   addr  = '0;
    logic [4*DATA_W-1:0]   wdata = '0;
    logic [3:0]            ack;
    logic [DATA_W-1:0]     rdata;
    logic                  busy, clear_done, mem_en, mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata = '0;

    always #5 clock = ~clock;

    sram_rr_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .clear_done(clear_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Background content of never-written words
    function automatic logic [DATA_W-1:0] bg(input logic [ADDR_W-1:0] a);
        return DATA_W'((32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    // SRAM model: write on enabled edge, read data registered one edge after the address
    logic [DATA_W-1:0] sram [logic [ADDR_W-1:0]];
    always @(posedge clock) begin
        if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : bg(mem_addr);
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [3:0]        m_ack = '0;
    logic [DATA_W-1:0] m_rdata = '0, m_result = '0, m_mem_wdata = '0;
    logic [ADDR_W-1:0] m_mem_addr = '0;
    logic              m_busy = 0, m_clear_done = 0, m_mem_en = 0, m_mem_we = 0;
    logic              m_active = 0, m_is_read = 0, m_clearing = 0;
    int                m_ptr = 0, m_g = 0, m_done_at = 0, clr_cnt = 0, edge_n = 0;
    int                n_cmp = 0, n_fail = 0;
    logic [3:0]        prev_ack = '0;
    bit                auto_drop = 1;
    int                q_idx[$], q_edge[$], q_en[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_edge();
        logic [3:0] elig;
        logic [ADDR_W-1:0] a;
        bit found;
        edge_n++;
        if (!reset) begin
            m_ack = '0; m_rdata = '0; m_busy = 0; m_mem_en = 0; m_mem_we = 0;
            m_mem_addr = '0; m_mem_wdata = '0; m_ptr = 0; m_active = 0; m_clear_done = 0;
`ifdef SRAM_SCHED_MEM_CLEAR_EN
            m_clearing = 1; clr_cnt = 0;
`endif
            return;
        end
        elig  = req & ~m_ack;
        m_ack = '0;
        m_mem_en = 0;
        if (m_clearing) begin
            if (clr_cnt == int'(DEPTH)) begin
                m_clearing = 0; m_clear_done = 1; m_busy = 0;
            end else begin
                m_mem_en = 1; m_mem_we = 1; m_mem_addr = ADDR_W'(clr_cnt); m_mem_wdata = '0;
                ref_mem[ADDR_W'(clr_cnt)] = '0; m_busy = 1; clr_cnt++;
            end
            return;
        end
        if (m_active) begin
            if (edge_n == m_done_at) begin
                m_ack[m_g] = 1'b1;
                if (m_is_read) m_rdata = m_result;
                m_busy = 0; m_ptr = (m_g + 1) % 4; m_active = 0;
            end
        end else if (m_clear_done) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!found && elig[i]) begin
                    found = 1;
                    a = addr[i*ADDR_W +: ADDR_W];
                    m_g = i; m_active = 1; m_done_at = edge_n + int'(LAT); m_busy = 1;
                    m_mem_en = 1; m_mem_we = we[i]; m_mem_addr = a;
                    m_mem_wdata = wdata[i*DATA_W +: DATA_W];
                    m_is_read = !we[i];
                    if (we[i]) ref_mem[a] = m_mem_wdata;
                    else m_result = ref_mem.exists(a) ? ref_mem[a] : bg(a);
                end
            end
        end
`ifndef SRAM_SCHED_MEM_CLEAR_EN
        m_clear_done = 1;
`endif
    endtask

    task automatic compare_all();
        check("ack",        64'(ack),        64'(m_ack));
        check("rdata",      64'(rdata),      64'(m_rdata));
        check("busy",       64'(busy),       64'(m_busy));
        check("clear_done", 64'(clear_done), 64'(m_clear_done));
        check("mem_en",     64'(mem_en),     64'(m_mem_en));
        check("mem_we",     64'(mem_we),     64'(m_mem_we));
        check("mem_addr",   64'(mem_addr),   64'(m_mem_addr));
        check("mem_wdata",  64'(mem_wdata),  64'(m_mem_wdata));
    endtask

    // One clock: predict, clock, sample 1ns later, then requesters drop after their ack cycle
    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
        if (auto_drop) req = req & ~prev_ack;
        prev_ack = m_ack;
    endtask

    task automatic set_req(input int i, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        we[i] = w;
        addr[i*ADDR_W +: ADDR_W] = a;
        wdata[i*DATA_W +: DATA_W] = d;
        req[i] = 1'b1;
    endtask

    task automatic run_acks(input int n, input int budget, input string tag);
        int b;
        b = 0;
        q_idx.delete(); q_edge.delete(); q_en.delete();
        while (q_idx.size() < n && b < budget) begin
            step();
            b++;
            if (mem_en) q_en.push_back(edge_n);
            for (int i = 0; i < 4; i++)
                if (ack[i]) begin q_idx.push_back(i); q_edge.push_back(edge_n); end
        end
        if (q_idx.size() < n) check({tag, "_timeout"}, 64'(q_idx.size()), 64'(n));
    endtask

    task automatic wait_clear(input int budget, output int acks_seen);
        int b;
        b = 0; acks_seen = 0;
        while (clear_done !== 1'b1 && b < budget) begin
            step(); b++;
            if (ack != 4'd0) acks_seen++;
        end
        check("clear_done_wait", 64'(clear_done), 64'd1);
    endtask

    task automatic sweep_zero_check();
        int nz;
        logic [ADDR_W-1:0] a;
        nz = 0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            a = ADDR_W'(k);
            if (!sram.exists(a) || sram[a] !== '0) nz++;
        end
        check("sweep_zero_words", 64'(nz), 64'd0);
    endtask

    initial begin
        int acks_seen, prev_g, rand_acks;
        logic [DATA_W-1:0] pre_val [5];

        // Reset and bring-up
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        wait_clear(int'(DEPTH) + 20, acks_seen);
`ifdef SRAM_SCHED_MEM_CLEAR_EN
        sweep_zero_check();
`endif

        // Preload through the scheduler with requester 1
        pre_val[0] = 32'hDEAD_BEEF;
        for (int k = 1; k < 5; k++) pre_val[k] = 32'hA000_0000 + 32'(k - 1);
        for (int k = 0; k < 5; k++) begin
            set_req(1, 1'b1, (k == 0) ? ADDR_W'(16'h0010) : ADDR_W'(16'h0100 + k - 1), pre_val[k]);
            run_acks(1, 20, "preload");
            step();
        end

        // Single read by requester 2
        set_req(2, 1'b0, ADDR_W'(16'h0010), 32'h0);
        run_acks(1, 20, "single_read");
        check("single_read_idx", 64'(q_idx.size() > 0 ? q_idx[0] : -1), 64'd2);
        check("single_read_rdata", 64'(rdata), 64'h0000_0000_DEAD_BEEF);
        check("single_read_en_pulses", 64'(q_en.size()), 64'd1);
        check("single_read_latency",
              64'((q_edge.size() > 0 && q_en.size() > 0) ? q_edge[0] - q_en[0] : -1), 64'(LAT));
        step();

        // Wrap and mask: pointer now at 3, requesters 0 and 3 held continuously
        auto_drop = 0;
        set_req(0, 1'b0, ADDR_W'(16'h0101), 32'h0);
        set_req(3, 1'b0, ADDR_W'(16'h0102), 32'h0);
        run_acks(4, 40, "wrap");
        req = 4'd0;
        auto_drop = 1;
        for (int k = 0; k < 4; k++)
            check("wrap_order", 64'(k < q_idx.size() ? q_idx[k] : -1), 64'((k % 2 == 0) ? 3 : 0));
        prev_g = -1;
        for (int k = 0; k < q_idx.size(); k++) begin
            check("wrap_no_repeat", 64'(q_idx[k] == prev_g), 64'd0);
            prev_g = q_idx[k];
        end
        step();

        // One access by requester 3 moves the pointer to 0
        set_req(3, 1'b0, ADDR_W'(16'h0103), 32'h0);
        run_acks(1, 20, "ptr_to_0");
        step();

        // Fairness: all four requesters at once, each drops after its ack
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, ADDR_W'(16'h0100 + i), 32'h0);
        run_acks(4, 40, "fair");
        for (int k = 0; k < 4; k++)
            check("fair_order", 64'(k < q_idx.size() ? q_idx[k] : -1), 64'(k));
        for (int k = 1; k < 4; k++)
            check("fair_spacing", 64'(k < q_edge.size() ? q_edge[k] - q_edge[k-1] : -1), 64'(LAT + 1));
        check("fair_last_rdata", 64'(rdata), 64'h0000_0000_A000_0003);
        step();

        // Write then read at the top address; the write ack leaves rdata alone
        set_req(0, 1'b1, ADDR_W'(16'h7FFF), 32'h1234_5678);
        run_acks(1, 20, "wr");
        check("wr_rdata_held", 64'(rdata), 64'h0000_0000_A000_0003);
        step();
        set_req(0, 1'b0, ADDR_W'(16'h7FFF), 32'h0);
        run_acks(1, 20, "rd_back");
        check("rd_back_rdata", 64'(rdata), 64'h0000_0000_1234_5678);
        step();

        // Reset in the middle of an access
        set_req(1, 1'b0, ADDR_W'(16'h0005), 32'h0);
        acks_seen = 0;
        for (int b = 0; b < 10 && mem_en !== 1'b1; b++) step();
        check("mid_reset_granted", 64'(mem_en), 64'd1);
        step();
        reset = 1'b0;
        req = 4'd0;
        step();
        check("mid_reset_ack", 64'(ack), 64'd0);
        check("mid_reset_mem_en", 64'(mem_en), 64'd0);
        check("mid_reset_busy", 64'(busy), 64'd0);
        check("mid_reset_rdata", 64'(rdata), 64'd0);
        check("mid_reset_clear_done", 64'(clear_done), 64'd0);
        reset = 1'b1;
        wait_clear(int'(DEPTH) + 20, acks_seen);
        check("mid_reset_no_ack", 64'(acks_seen), 64'd0);
`ifdef SRAM_SCHED_MEM_CLEAR_EN
        sweep_zero_check();
`endif
        step();

        // Randomized traffic over a small address window to exercise read-after-write
        rand_acks = 0;
        for (int c = 0; c < 1200; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(2) == 0)
                    set_req(i, 1'($urandom_range(1)), ADDR_W'($urandom_range(15)), $urandom);
                else if (req[i] && $urandom_range(7) == 0) begin
                    addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(15));
                    wdata[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            step();
            if (ack != 4'd0) rand_acks++;
        end
        check("random_progress", 64'(rand_acks > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
